accum_seq: RTL and testbench

Sequential 8-bit accumulator that feeds the team's ripple adder and consumes its result. It sums a run of N operands under a valid/ready handshake and reports the final sum, a sticky signed-overflow flag and a carry-out count. It sits between the operand source and the ALU result bus. Each accepted beat issues one add through a single instance of the existing `adder8bit`.

---
 rtl/accum_seq_pkg.sv | 27 ++
 rtl/adder8bit.sv | 40 ++++
 rtl/accum_seq.sv | 133 +++++++++++++
 tb/tb_accum_seq.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_seq_pkg.sv
// ============================================================================
// Module   : accum_seq_pkg
// Purpose  : Shared types and constants for the sequential accumulator:
//            FSM state encoding, default widths and the datapath width.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package accum_seq_pkg;

    // Datapath width of the adder and accumulator.
    localparam int c_DATA_W    = 8;

    // Default widths of the run-length input and the carry-out counter.
    localparam int c_LEN_W_DEF = 4;
    localparam int c_CNT_W_DEF = 4;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : accum_seq_pkg

`default_nettype wire

// File: rtl/adder8bit.sv
// ============================================================================
// Module   : adder8bit
// Purpose  : 8-bit ripple-carry adder with signed-overflow clamp.
//            The result is forced to zero whenever the add overflows as a
//            signed operation; otherwise it is the modulo-256 sum.
// Ports    : a_i, b_i   - operands
//            sum_o      - clamped result
//            cout_o     - carry out of bit 7
//            flow_o     - signed overflow (carry out of bit 7 XOR carry into it)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder8bit
    import accum_seq_pkg::*;
(
    input  logic [c_DATA_W-1:0] a_i,
    input  logic [c_DATA_W-1:0] b_i,
    output logic [c_DATA_W-1:0] sum_o,
    output logic                cout_o,
    output logic                flow_o
);

    logic [c_DATA_W:0]   w_carry;
    logic [c_DATA_W-1:0] w_raw;

    assign w_carry[0] = 1'b0;

    for (genvar i = 0; i < c_DATA_W; i++) begin : g_bit
        assign w_raw[i]     = a_i[i] ^ b_i[i] ^ w_carry[i];
        assign w_carry[i+1] = (a_i[i] & b_i[i]) | (w_carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = w_carry[c_DATA_W];
    assign flow_o = w_carry[c_DATA_W] ^ w_carry[c_DATA_W-1];
    assign sum_o  = flow_o ? '0 : w_raw;

endmodule : adder8bit

`default_nettype wire

// File: rtl/accum_seq.sv
// ============================================================================
// Module   : accum_seq
// Purpose  : Sequential accumulator. Sums a run of len_i operands accepted
//            over a valid/ready handshake, then presents the final sum, a
//            sticky signed-overflow flag and a saturating carry-out count
//            until the consumer takes them.
// Ports    : clk, rst                  - clock, async active-high reset
//            start_i, len_i            - begin a run of len_i operands (IDLE)
//            in_valid_i/in_ready_o     - operand handshake, in_data_i operand
//            out_valid_o/out_ready_i   - result handshake
//            out_sum_o, out_ovf_o,
//            out_carries_o             - result fields (registered)
//            busy_o                    - run in progress or result pending
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module accum_seq
    import accum_seq_pkg::*;
#(
    parameter int LEN_W = c_LEN_W_DEF,
    parameter int CNT_W = c_CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [LEN_W-1:0]    len_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [c_DATA_W-1:0] in_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [c_DATA_W-1:0] out_sum_o,
    output logic                out_ovf_o,
    output logic [CNT_W-1:0]    out_carries_o,
    output logic                busy_o
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [LEN_W-1:0] c_LEN_ONE = LEN_W'(1);

    state_t              state_q,     state_d;
    logic [c_DATA_W-1:0] acc_q,       acc_d;
    logic                ovf_q,       ovf_d;
    logic [CNT_W-1:0]    carries_q,   carries_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;

    logic [c_DATA_W-1:0] w_sum;
    logic                w_cout;
    logic                w_flow;
    logic                w_hs;

    adder8bit u_adder (
        .a_i    (acc_q),
        .b_i    (in_data_i),
        .sum_o  (w_sum),
        .cout_o (w_cout),
        .flow_o (w_flow)
    );

    assign w_hs = in_valid_i && (state_q == ST_ACCUM);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        carries_d   = carries_q;
        remaining_d = remaining_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    acc_d       = '0;
                    ovf_d       = 1'b0;
                    carries_d   = '0;
                    remaining_d = len_i;
                    state_d     = (len_i == '0) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_hs) begin
                    // The adder already clamps to zero on overflow, so the
                    // next beat restarts from 0 without extra muxing here.
                    acc_d       = w_sum;
                    ovf_d       = ovf_q | w_flow;
                    if (w_cout && (carries_q != c_CNT_MAX)) begin
                        carries_d = carries_q + 1'b1;
                    end
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == c_LEN_ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            carries_q   <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            carries_q   <= carries_d;
            remaining_q <= remaining_d;
        end
    end

    // All outputs come from registers or state decode; in_data_i never
    // reaches an output combinationally.
    assign in_ready_o    = (state_q == ST_ACCUM);
    assign out_valid_o   = (state_q == ST_DONE);
    assign busy_o        = (state_q == ST_ACCUM) || (state_q == ST_DONE);
    assign out_sum_o     = acc_q;
    assign out_ovf_o     = ovf_q;
    assign out_carries_o = carries_q;

endmodule : accum_seq

`default_nettype wire

// File: tb/tb_accum_seq.sv
// ============================================================================
// Module   : tb_accum_seq
// Purpose  : Self-checking bench for accum_seq. Expected results are queued
//            when a run starts and compared when the result handshake fires.
//            The carry counter is instantiated 2 bits wide so saturation is
//            reachable within a 15-operand run.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accum_seq;

    localparam int LEN_W   = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [7:0]       sum;
        logic             ovf;
        logic [CNT_W-1:0] car;
    } exp_t;

    typedef struct packed {
        logic [4:0]        n;
        logic [15:0][7:0]  d;
        logic [7:0]        sum;
        logic              ovf;
        logic [CNT_W-1:0]  car;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_i = 1'b0;
    logic [LEN_W-1:0] len_i = '0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [7:0]       in_data_i = '0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b0;
    logic [7:0]       out_sum_o;
    logic             out_ovf_o;
    logic [CNT_W-1:0] out_carries_o;
    logic             busy_o;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    accum_seq #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .len_i         (len_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_data_i     (in_data_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_sum_o     (out_sum_o),
        .out_ovf_o     (out_ovf_o),
        .out_carries_o (out_carries_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic, overflow judged by operand
    // and result signs.
    function automatic exp_t model(input int n, input logic [15:0][7:0] d);
        exp_t       e;
        logic [7:0] acc;
        logic [8:0] full;
        logic       v;
        int         c;
        acc = 8'h00; e.ovf = 1'b0; c = 0;
        for (int i = 0; i < n; i++) begin
            full = {1'b0, acc} + {1'b0, d[i]};
            v    = (acc[7] == d[i][7]) && (full[7] != acc[7]);
            if (full[8] && c < CNT_MAX) c++;
            e.ovf = e.ovf | v;
            acc   = v ? 8'h00 : full[7:0];
        end
        e.sum = acc;
        e.car = CNT_W'(c);
        return e;
    endfunction

    function automatic vec_t mk(input int n, input logic [7:0] b0, b1, b2, b3, b4, b5,
                                input logic [7:0] sum, input logic ovf, input int car);
        vec_t v;
        v     = '0;
        v.n   = 5'(n);
        v.d[0] = b0; v.d[1] = b1; v.d[2] = b2; v.d[3] = b3; v.d[4] = b4; v.d[5] = b5;
        v.sum = sum;
        v.ovf = ovf;
        v.car = CNT_W'(car);
        return v;
    endfunction

    // Result monitor: a handshake fires at the next rising edge when both
    // valid and ready are seen at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid_o && out_ready_i) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_sum", 32'(out_sum_o), 32'(e.sum));
                    check("out_ovf", 32'(out_ovf_o), 32'(e.ovf));
                    check("out_carries", 32'(out_carries_o), 32'(e.car));
                end
            end
        end
    end

    // Start a run and feed operands until out_valid; vpat bit c gates
    // in_valid in the c-th ACCUM cycle. edges counts rising edges from the
    // one that samples start to the one after which out_valid is seen.
    task automatic run_to_done(input int n, input logic [15:0][7:0] d,
                               input logic [15:0] vpat, output int edges,
                               output logic saw_ready);
        int   beat;
        int   c;
        logic rdy;
        beat = 0; c = 0; saw_ready = 1'b0;
        start_i = 1'b1;
        len_i   = LEN_W'(n);
        @(posedge clk); #1;
        edges   = 1;
        start_i = 1'b0;
        len_i   = '0;
        while (!out_valid_o && edges < 100) begin
            rdy = in_ready_o;
            if (rdy) saw_ready = 1'b1;
            in_valid_i = rdy && (beat < n) && ((c > 15) ? 1'b1 : vpat[c]);
            in_data_i  = (beat < 16) ? d[beat] : 8'h00;
            if (rdy) c++;
            @(posedge clk); #1;
            edges++;
            if (in_valid_i && rdy) beat++;
        end
        in_valid_i = 1'b0;
        in_data_i  = 8'h00;
        check("reach_done", 32'(out_valid_o), 32'd1);
    endtask

    task automatic finish_out();
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        out_ready_i = 1'b0;
        check("post_hs_valid", 32'(out_valid_o), 32'd0);
        check("post_hs_ready", 32'(in_ready_o), 32'd0);
        check("post_hs_busy", 32'(busy_o), 32'd0);
    endtask

    task automatic do_run(input int n, input logic [15:0][7:0] d, input exp_t e);
        int   edges;
        logic saw;
        sb.push_back(e);
        run_to_done(n, d, 16'hFFFF, edges, saw);
        check("latency", 32'(edges), 32'(n + 1));
        if (n == 0) check("len0_no_ready", 32'(saw), 32'd0);
        finish_out();
    endtask

    initial begin
        vec_t             vecs[7];
        exp_t             e;
        logic [15:0][7:0] d;
        int               edges;
        int               n;
        logic             saw;

        vecs[0] = mk(3, 8'd10,  8'd20,  8'd30,  8'h00, 8'h00, 8'h00, 8'd60,  1'b0, 0);
        vecs[1] = mk(3, 8'd100, 8'd50,  8'd7,   8'h00, 8'h00, 8'h00, 8'd7,   1'b1, 0);
        vecs[2] = mk(2, 8'hFF,  8'h02,  8'h00,  8'h00, 8'h00, 8'h00, 8'h01,  1'b0, 1);
        vecs[3] = mk(0, 8'h00,  8'h00,  8'h00,  8'h00, 8'h00, 8'h00, 8'h00,  1'b0, 0);
        vecs[4] = mk(6, 8'hFF,  8'hFF,  8'hFF,  8'hFF, 8'hFF, 8'hFF, 8'hFA,  1'b0, 3);
        vecs[5] = mk(2, 8'h80,  8'h80,  8'h00,  8'h00, 8'h00, 8'h00, 8'h00,  1'b1, 1);
        vecs[6] = mk(1, 8'h7F,  8'h00,  8'h00,  8'h00, 8'h00, 8'h00, 8'h7F,  1'b0, 0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(in_ready_o), 32'd0);
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_sum", 32'(out_sum_o), 32'd0);
        check("rst_ovf", 32'(out_ovf_o), 32'd0);
        check("rst_carries", 32'(out_carries_o), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven runs.
        for (int i = 0; i < 7; i++) begin
            e.sum = vecs[i].sum;
            e.ovf = vecs[i].ovf;
            e.car = vecs[i].car;
            do_run(int'(vecs[i].n), vecs[i].d, e);
        end

        // Backpressure on input, then a held result with start pulses.
        d = '0;
        d[0] = 8'd1; d[1] = 8'd2; d[2] = 8'd3; d[3] = 8'd4;
        e.sum = 8'd10; e.ovf = 1'b0; e.car = '0;
        sb.push_back(e);
        run_to_done(4, d, 16'b0000_0000_0010_1101, edges, saw);
        for (int i = 0; i < 5; i++) begin
            start_i = (i % 2 == 0);
            len_i   = 4'd3;
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid_o), 32'd1);
            check("hold_ready", 32'(in_ready_o), 32'd0);
            check("hold_sum", 32'(out_sum_o), 32'd10);
            check("hold_carries", 32'(out_carries_o), 32'd0);
        end
        start_i = 1'b0;
        len_i   = '0;
        finish_out();
        @(posedge clk); #1;
        check("start_not_queued", 32'(busy_o), 32'd0);

        // Reset mid-run: two of five beats accepted, then async reset.
        start_i = 1'b1;
        len_i   = 4'd5;
        @(posedge clk); #1;
        start_i    = 1'b0;
        in_valid_i = 1'b1;
        in_data_i  = 8'd9;
        repeat (2) @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        check("mid_busy", 32'(busy_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_ready", 32'(in_ready_o), 32'd0);
        check("async_rst_busy", 32'(busy_o), 32'd0);
        check("async_rst_valid", 32'(out_valid_o), 32'd0);
        check("async_rst_sum", 32'(out_sum_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        d = '0;
        d[0] = 8'd5;
        e.sum = 8'd5; e.ovf = 1'b0; e.car = '0;
        do_run(1, d, e);

        // Model-checked runs, including the maximum length.
        for (int r = 0; r < 4; r++) begin
            n = (r == 0) ? 15 : int'($urandom_range(1, 15));
            for (int i = 0; i < 16; i++) d[i] = 8'($urandom_range(0, 255));
            do_run(n, d, model(n, d));
        end

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_accum_seq

`default_nettype wire
